// File: rtl/systolic_mm_engine.sv
// Output-stationary SIZE x SIZE signed matrix-multiply tile (C = A x B or C += A x B).
// Operands are skewed internally; results drain one row per beat over valid/ready.
module systolic_mm_engine #(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 10,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_acc,
    input  logic [SIZE*DATA_WIDTH-1:0]     in_a,
    input  logic [SIZE*DATA_WIDTH-1:0]     in_b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(SIZE)-1:0]        out_row,
    output logic [SIZE*ACC_WIDTH-1:0]      out_data,
    output logic                           busy,
    output logic                           done
);
    localparam int RW  = $clog2(SIZE);
    localparam int FW  = $clog2(2*SIZE);
    localparam int NSK = SIZE*(SIZE-1)/2;
    localparam int PW  = 2*DATA_WIDTH;
    localparam logic [RW-1:0] LAST_BEAT  = RW'(SIZE-1);
    localparam logic [FW-1:0] LAST_FLUSH = FW'(2*SIZE-3);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t        state;
    logic [RW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic          step;
    logic          first;

    // Row/column i skew lines are packed back to back: line i starts at i*(i-1)/2.
    logic signed [DATA_WIDTH-1:0] skew_a [NSK];
    logic signed [DATA_WIDTH-1:0] skew_b [NSK];
    logic signed [DATA_WIDTH-1:0] a_src  [SIZE];
    logic signed [DATA_WIDTH-1:0] b_src  [SIZE];
    logic signed [DATA_WIDTH-1:0] a_edge [SIZE];
    logic signed [DATA_WIDTH-1:0] b_edge [SIZE];
    logic signed [DATA_WIDTH-1:0] a_in   [SIZE][SIZE];
    logic signed [DATA_WIDTH-1:0] b_in   [SIZE][SIZE];
    logic signed [DATA_WIDTH-1:0] a_fwd  [SIZE][SIZE-1];
    logic signed [DATA_WIDTH-1:0] b_fwd  [SIZE-1][SIZE];
    logic signed [PW-1:0]         prod   [SIZE][SIZE];
    logic signed [ACC_WIDTH-1:0]  acc    [SIZE][SIZE];

    function automatic int unsigned skew_base(input int unsigned n);
        return n*(n-1)/2;
    endfunction

    assign in_ready = (state == IDLE) || (state == LOAD);
    assign step     = (in_valid && in_ready) || (state == FLUSH);
    assign first    = in_valid && (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        for (int unsigned i = 0; i < SIZE; i++) begin
            a_src[i] = (state == FLUSH) ? '0 : in_a[i*DATA_WIDTH +: DATA_WIDTH];
            b_src[i] = (state == FLUSH) ? '0 : in_b[i*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (i == 0) begin
                a_edge[i] = a_src[i];
                b_edge[i] = b_src[i];
            end else begin
                a_edge[i] = skew_a[skew_base(i) + i - 1];
                b_edge[i] = skew_b[skew_base(i) + i - 1];
            end
        end
        for (int unsigned i = 0; i < SIZE; i++) begin
            for (int unsigned j = 0; j < SIZE; j++) begin
                if (j == 0) a_in[i][j] = a_edge[i];
                else        a_in[i][j] = a_fwd[i][j-1];
                if (i == 0) b_in[i][j] = b_edge[j];
                else        b_in[i][j] = b_fwd[i-1][j];
                prod[i][j] = a_in[i][j] * b_in[i][j];
            end
        end
    end

    // Beat 0 may only see a nonzero operand at PE(0,0); every other PE multiplies zeros,
    // so selecting "prod" vs "acc+prod" tile-wide clears or keeps the whole result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skew_a <= '{default: '0};
            skew_b <= '{default: '0};
            a_fwd  <= '{default: '{default: '0}};
            b_fwd  <= '{default: '{default: '0}};
            acc    <= '{default: '{default: '0}};
        end else if (step) begin
            for (int unsigned i = 1; i < SIZE; i++) begin
                skew_a[skew_base(i)] <= a_src[i];
                skew_b[skew_base(i)] <= b_src[i];
                for (int unsigned d = 1; d < i; d++) begin
                    skew_a[skew_base(i) + d] <= skew_a[skew_base(i) + d - 1];
                    skew_b[skew_base(i) + d] <= skew_b[skew_base(i) + d - 1];
                end
            end
            for (int unsigned i = 0; i < SIZE; i++) begin
                for (int unsigned j = 0; j < SIZE; j++) begin
                    if (j < SIZE-1) a_fwd[i][j] <= a_in[i][j];
                    if (i < SIZE-1) b_fwd[i][j] <= b_in[i][j];
                    if (first && !in_acc) acc[i][j] <= ACC_WIDTH'(prod[i][j]);
                    else                  acc[i][j] <= acc[i][j] + ACC_WIDTH'(prod[i][j]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    state    <= LOAD;
                    beat_cnt <= RW'(1);
                end
                LOAD: if (in_valid) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state     <= FLUSH;
                        beat_cnt  <= '0;
                        flush_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + RW'(1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == LAST_FLUSH) begin
                        state     <= DRAIN;
                        flush_cnt <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                DRAIN: if (out_ready) begin
                    if (out_row == LAST_BEAT) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_row   <= '0;
                        done      <= 1'b1;
                    end else begin
                        out_row <= out_row + RW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned j = 0; j < SIZE; j++)
            out_data[j*ACC_WIDTH +: ACC_WIDTH] = acc[out_row][j];
    end
endmodule
